regime_scan_ctrl: RTL and testbench

REGIME_SCAN_CTRL -- requirements
Module: regime_scan_ctrl

---
 rtl/ppu_pkg.sv | 14 +
 rtl/regime_scan_ctrl_if.sv | 36 +++
 rtl/regime_scan_ctrl_clo.sv | 25 ++
 rtl/regime_scan_ctrl.sv | 103 ++++++++++
 tb/tb_regime_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_pkg.sv
// Shared definitions for the posit regime scan datapath:
// scan FSM encoding and default word/chunk widths.
package ppu_pkg;

    localparam int PPU_W = 32;
    localparam int PPU_C = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

endpackage

// File: rtl/regime_scan_ctrl_if.sv
// Valid/ready bundle between the regime scanner and its producer/consumer.
// master = producer/consumer side, slave = scanner side.
interface regime_scan_ctrl_if import ppu_pkg::*; #(
    parameter int W = PPU_W,
    parameter int R = $clog2(W + 1)
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_word;
    logic         out_valid;
    logic         out_ready;
    logic [R-1:0] run_len;
    logic         run_bit;

    modport master (
        output in_valid,
        output in_word,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  run_len,
        input  run_bit
    );

    modport slave (
        input  in_valid,
        input  in_word,
        input  out_ready,
        output in_ready,
        output out_valid,
        output run_len,
        output run_bit
    );

endinterface

// File: rtl/regime_scan_ctrl_clo.sv
// Combinational count-leading-ones over one C-bit chunk,
// plus an all-ones flag for the scan termination test.
module clo_chunk #(
    parameter int C  = 8,
    parameter int CW = $clog2(C + 1)
) (
    input  logic [C-1:0]  x_i,
    output logic [CW-1:0] cnt_o,
    output logic          all_ones_o
);

    logic run;

    always_comb begin
        cnt_o = '0;
        run   = 1'b1;
        for (int i = C - 1; i >= 0; i--) begin
            run = run & x_i[i];
            if (run) cnt_o = cnt_o + CW'(1);
        end
    end

    assign all_ones_o = &x_i;

endmodule

// File: rtl/regime_scan_ctrl.sv
// Multi-cycle scan of the leading run of identical bits, one chunk per cycle.
// Define REGIME_SCAN_EARLY_EXIT_EN to stop at the first chunk that breaks the run.
module regime_scan_ctrl import ppu_pkg::*; #(
    parameter int W = PPU_W,
    parameter int C = PPU_C,
    parameter int R = $clog2(W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    regime_scan_ctrl_if.slave bus
);

    localparam int K  = W / C;
    localparam int CW = $clog2(C + 1);
    localparam int JW = (K > 1) ? $clog2(K) : 1;

    scan_state_t   state_q;
    logic [W-1:0]  word_q;
    logic          bit_q;
    logic [R-1:0]  acc_q;
    logic [JW-1:0] j_q;
    logic          stop_q;
    logic          rdy_q;
    logic          vld_q;

    logic [C-1:0]  chunk;
    logic [CW-1:0] cnt;
    logic          all1;
    logic          last;
    logic          fin;

    // Bits equal to the run value become ones, so leading ones = run length.
    assign chunk = ~(word_q[W-1 -: C] ^ {C{bit_q}});
    assign last  = (j_q == JW'(K - 1));

`ifdef REGIME_SCAN_EARLY_EXIT_EN
    assign fin = last | ~all1;
`else
    assign fin = last;
`endif

    clo_chunk #(
        .C  (C),
        .CW (CW)
    ) u_clo (
        .x_i        (chunk),
        .cnt_o      (cnt),
        .all_ones_o (all1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            bit_q   <= 1'b0;
            acc_q   <= '0;
            j_q     <= '0;
            stop_q  <= 1'b0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid && rdy_q) begin
                        word_q  <= bus.in_word;
                        bit_q   <= bus.in_word[W-1];
                        acc_q   <= '0;
                        j_q     <= '0;
                        stop_q  <= 1'b0;
                        rdy_q   <= 1'b0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    // A broken run freezes the count for the remaining chunks.
                    if (!stop_q) acc_q <= acc_q + R'(cnt);
                    stop_q <= stop_q | ~all1;
                    word_q <= word_q << C;
                    if (fin) begin
                        state_q <= DONE;
                        vld_q   <= 1'b1;
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                        vld_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = rdy_q & ~rst;
    assign bus.out_valid = vld_q;
    assign bus.run_len   = acc_q;
    assign bus.run_bit   = bit_q;

endmodule

// File: tb/tb_regime_scan_ctrl.sv
// Directed bench for regime_scan_ctrl at W=32, C=8.
// Latency expectations follow REGIME_SCAN_EARLY_EXIT_EN when defined.
module tb_regime_scan_ctrl;

    localparam bit EE =
`ifdef REGIME_SCAN_EARLY_EXIT_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    regime_scan_ctrl_if #(.W(32), .R(6)) bus ();

    regime_scan_ctrl #(
        .W (32),
        .C (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [31:0] w, output int lat);
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_word  = ~w;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset out_valid: got %b want 0", bus.out_valid);
        end
        n_chk++;
        if (bus.run_len !== 6'd0) begin
            n_fail++;
            $display("FAIL reset run_len: got %0d want 0", bus.run_len);
        end
        n_chk++;
        if (bus.run_bit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset run_bit: got %b want 0", bus.run_bit);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] tw [7] = '{32'hFF00_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                                32'h0000_0000, 32'h0FFF_FFFF, 32'h00F0_0000,
                                32'hFFFE_0000};
        int          tl [7] = '{8, 1, 32, 32, 4, 8, 15};
        logic        tb [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int          te [7] = '{2, 1, 4, 4, 1, 2, 2};
        int          lat;
        int          want_lat;
        for (int i = 0; i < 7; i++) begin
            want_lat = EE ? te[i] : 4;
            send(tw[i], lat);
            n_chk++;
            if (lat != want_lat) begin
                n_fail++;
                $display("FAIL vec%0d latency: got %0d want %0d", i, lat, want_lat);
            end
            n_chk++;
            if (bus.run_len !== 6'(tl[i])) begin
                n_fail++;
                $display("FAIL vec%0d run_len: got %0d want %0d", i, bus.run_len, tl[i]);
            end
            n_chk++;
            if (bus.run_bit !== tb[i]) begin
                n_fail++;
                $display("FAIL vec%0d run_bit: got %b want %b", i, bus.run_bit, tb[i]);
            end
            release_out();
            n_chk++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d return: in_ready %b out_valid %b want 1 0",
                         i, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        send(32'h0000_0001, lat);
        n_chk++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL bp latency: got %0d want 4", lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_chk++;
            if (bus.out_valid !== 1'b1 || bus.run_len !== 6'd31 || bus.run_bit !== 1'b0) begin
                n_fail++;
                $display("FAIL bp hold%0d: valid %b len %0d bit %b want 1 31 0",
                         c, bus.out_valid, bus.run_len, bus.run_bit);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp release: in_ready %b out_valid %b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_ignore_busy();
        int lat;
        bus.in_valid = 1'b1;
        bus.in_word  = 32'hFF00_0000;
        @(posedge clk);
        #1;
        bus.in_word = 32'h0000_0000;
        n_chk++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy in_ready: got %b want 0", bus.in_ready);
        end
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.run_len !== 6'd8 || bus.run_bit !== 1'b1) begin
            n_fail++;
            $display("FAIL busy result: valid %b len %0d bit %b want 1 8 1",
                     bus.out_valid, bus.run_len, bus.run_bit);
        end
        release_out();
        @(posedge clk);
        #1;
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL busy idle: in_ready %b out_valid %b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_scan();
        int   lat;
        logic seen;
        bus.in_valid = 1'b1;
        bus.in_word  = 32'h0000_00F0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.run_len !== 6'd0 || bus.run_bit !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst outputs: valid %b len %0d bit %b want 0 0 0",
                     bus.out_valid, bus.run_len, bus.run_bit);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst stale result: got out_valid 1 want 0");
        end
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst in_ready: got %b want 1", bus.in_ready);
        end
        send(32'hC000_0000, lat);
        n_chk++;
        if (lat != (EE ? 1 : 4)) begin
            n_fail++;
            $display("FAIL midrst latency: got %0d want %0d", lat, EE ? 1 : 4);
        end
        n_chk++;
        if (bus.run_len !== 6'd2 || bus.run_bit !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst next: len %0d bit %b want 2 1", bus.run_len, bus.run_bit);
        end
        release_out();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        clk           = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_ignore_busy();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
